// File: rtl/wb_io_arbiter.sv
// Round-robin Wishbone arbiter sharing one IO slave port between NUM_M masters.
// Optional stall timeout enabled with `define WB_ARB_TIMEOUT_EN.
module wb_io_arbiter #(
    parameter int NUM_M       = 2,
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_M*AW-1:0]     m_adr_i,
    input  logic [NUM_M*DW-1:0]     m_dat_i,
    input  logic [NUM_M*(DW/8)-1:0] m_sel_i,
    input  logic [NUM_M-1:0]        m_we_i,
    input  logic [NUM_M-1:0]        m_cyc_i,
    input  logic [NUM_M-1:0]        m_stb_i,
    output logic [DW-1:0]           m_dat_o,
    output logic [NUM_M-1:0]        m_ack_o,
    output logic [NUM_M-1:0]        m_err_o,
    output logic [AW-1:0]           s_adr_o,
    output logic [DW-1:0]           s_dat_o,
    output logic [DW/8-1:0]         s_sel_o,
    output logic                    s_we_o,
    output logic                    s_cyc_o,
    output logic                    s_stb_o,
    input  logic [DW-1:0]           s_dat_i,
    input  logic                    s_ack_i,
    input  logic                    s_err_i,
    output logic [NUM_M-1:0]        grant_o
);

    localparam int SW = DW / 8;
    localparam int IW = (NUM_M > 1) ? $clog2(NUM_M) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    gidx_q, gidx_d;
    logic [IW-1:0]    last_q, last_d;
    logic [NUM_M-1:0] grant_q, grant_d;

    logic             busy_s;
    logic             cyc_g_s;
    logic             stb_g_s;
    logic             timeout_s;
    logic             win_found_s;
    logic [IW-1:0]    win_idx_s;
    logic [IW-1:0]    cand_s;

    assign busy_s  = (state_q == BUSY);
    assign cyc_g_s = m_cyc_i[gidx_q];
    assign stb_g_s = m_stb_i[gidx_q];
    assign grant_o = grant_q;

`ifdef WB_ARB_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

    logic [CW-1:0] stall_q, stall_d;
    logic          stall_s;

    // Stall detection uses the unforced strobe so the timeout cycle itself counts as a stall.
    always_comb begin
        stall_s   = busy_s && stb_g_s && !s_ack_i && !s_err_i;
        timeout_s = stall_s && (stall_q == CW'(TIMEOUT_CYC - 1));
    end

    // Stall counter next state: clears on ack, err or leaving BUSY, holds while strobe is low.
    always_comb begin
        stall_d = stall_q;
        if ((state_d != BUSY) || s_ack_i || s_err_i) begin
            stall_d = {CW{1'b0}};
        end else if (stall_s) begin
            stall_d = stall_q + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            stall_d = stall_q;
        end
    end

    // Stall counter register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_q <= {CW{1'b0}};
        end else begin
            stall_q <= stall_d;
        end
    end
`else
    logic [31:0] unused_timeout_s;
    assign unused_timeout_s = 32'(TIMEOUT_CYC);
    assign timeout_s        = 1'b0;
    logic        unused_stb_s;
    assign unused_stb_s     = stb_g_s;
`endif

    // Round-robin scan starting just after the last winner.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = last_q;
        cand_s      = last_q;
        for (int i = 1; i <= NUM_M; i++) begin
            cand_s = IW'((int'(last_q) + i) % NUM_M);
            if (!win_found_s && m_cyc_i[cand_s]) begin
                win_found_s = 1'b1;
                win_idx_s   = cand_s;
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // FSM next state and grant bookkeeping.
    always_comb begin
        state_d = state_q;
        gidx_d  = gidx_q;
        last_d  = last_q;
        grant_d = grant_q;
        case (state_q)
            IDLE: begin
                if (win_found_s) begin
                    state_d = BUSY;
                    gidx_d  = win_idx_s;
                    last_d  = win_idx_s;
                    for (int k = 0; k < NUM_M; k++) begin
                        grant_d[k] = (IW'(k) == win_idx_s);
                    end
                end else begin
                    grant_d = {NUM_M{1'b0}};
                end
            end
            BUSY: begin
                if (!cyc_g_s || timeout_s) begin
                    state_d = IDLE;
                    grant_d = {NUM_M{1'b0}};
                end else begin
                    state_d = BUSY;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = {NUM_M{1'b0}};
            end
        endcase
    end

    // FSM and grant registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            gidx_q  <= {IW{1'b0}};
            last_q  <= IW'(NUM_M - 1);
            grant_q <= {NUM_M{1'b0}};
        end else begin
            state_q <= state_d;
            gidx_q  <= gidx_d;
            last_q  <= last_d;
            grant_q <= grant_d;
        end
    end

    // Bus routing: granted master to slave, slave responses to granted master only.
    always_comb begin
        s_adr_o = {AW{1'b0}};
        s_dat_o = {DW{1'b0}};
        s_sel_o = {SW{1'b0}};
        s_we_o  = 1'b0;
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        m_dat_o = {DW{1'b0}};
        m_ack_o = {NUM_M{1'b0}};
        m_err_o = {NUM_M{1'b0}};
        if (busy_s) begin
            s_adr_o = m_adr_i[int'(gidx_q)*AW +: AW];
            s_dat_o = m_dat_i[int'(gidx_q)*DW +: DW];
            s_sel_o = m_sel_i[int'(gidx_q)*SW +: SW];
            s_we_o  = m_we_i[gidx_q];
            s_cyc_o = cyc_g_s && !timeout_s;
            s_stb_o = stb_g_s && !timeout_s;
            m_dat_o = s_dat_i;
            for (int k = 0; k < NUM_M; k++) begin
                m_ack_o[k] = s_ack_i && grant_q[k];
                m_err_o[k] = (s_err_i || timeout_s) && grant_q[k];
            end
        end else begin
            m_dat_o = {DW{1'b0}};
        end
    end

endmodule
